// File: rtl/servo_motion_sequencer_if.sv
// rtl/servo_motion_sequencer_if.sv - command, current-sense and PWM-side signals of the motion sequencer
interface servo_motion_sequencer_if #(
    parameter int ANG_W = 8,
    parameter int CUR_W = 12
);
    logic             cmd_valid;
    logic [ANG_W-1:0] cmd_angle;
    logic             cmd_ready;
    logic [CUR_W-1:0] current_meas;
    logic             fault_clr;
    logic [ANG_W-1:0] setpoint;
    logic             setpoint_upd;
    logic             frame_tick;
    logic             pwm_en;
    logic             busy;
    logic             fault;

    modport master (
        output cmd_valid, cmd_angle, current_meas, fault_clr,
        input  cmd_ready, setpoint, setpoint_upd, frame_tick, pwm_en, busy, fault
    );

    modport slave (
        input  cmd_valid, cmd_angle, current_meas, fault_clr,
        output cmd_ready, setpoint, setpoint_upd, frame_tick, pwm_en, busy, fault
    );
endinterface

// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - frame-paced setpoint slew toward a commanded angle with overcurrent trip
module servo_motion_sequencer #(
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int ANG_W        = 8,
    parameter int MAX_ANGLE    = 180,
    parameter int PARK_ANGLE   = 90,
    parameter int STEP_DEG     = 6,
    parameter int CUR_W        = 12,
    parameter int I_LIMIT      = 3000,
    parameter int OC_FRAMES    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    servo_motion_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam int OC_W  = $clog2(OC_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [ANG_W-1:0] MAX_A    = ANG_W'(MAX_ANGLE);
    localparam logic [ANG_W-1:0] PARK_A   = ANG_W'(PARK_ANGLE);
    localparam logic [ANG_W-1:0] STEP_A   = ANG_W'(STEP_DEG);
    localparam logic [CUR_W-1:0] I_LIM    = CUR_W'(I_LIMIT);
    localparam logic [OC_W-1:0]  OC_MAX   = OC_W'(OC_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_FAULT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [ANG_W-1:0] setpoint_q, setpoint_d;
    logic [ANG_W-1:0] target_q, target_d;
    logic [OC_W-1:0]  oc_q, oc_d;
    logic             upd_q, upd_d;

    logic [ANG_W-1:0] clamped, diff, stepped;
    logic [OC_W-1:0]  oc_inc;
    logic             xfer, trip, up;

    assign cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    assign tick_d = (cnt_d == LAST_CNT);

    assign clamped = (bus.cmd_angle > MAX_A) ? MAX_A : bus.cmd_angle;
    assign xfer    = bus.cmd_valid && (state_q == ST_IDLE);

    // Over-limit frames count up and saturate; any under-limit frame restarts the run.
    assign oc_inc = (bus.current_meas >= I_LIM) ? ((oc_q == OC_MAX) ? oc_q : oc_q + 1'b1) : '0;
    assign trip   = tick_q && (state_q != ST_FAULT) && (oc_inc == OC_MAX);

    // Step is bounded by the remaining distance so the ramp lands exactly on target.
    assign up      = (target_q > setpoint_q);
    assign diff    = up ? (target_q - setpoint_q) : (setpoint_q - target_q);
    assign stepped = (diff <= STEP_A) ? target_q
                   : (up ? setpoint_q + STEP_A : setpoint_q - STEP_A);

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        target_d   = target_q;
        oc_d       = oc_q;
        upd_d      = 1'b0;
        if (tick_q && (state_q != ST_FAULT)) begin
            oc_d = oc_inc;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    target_d = clamped;
                end
                if (trip) begin
                    state_d = ST_FAULT;
                end else if (xfer && (clamped != setpoint_q)) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (trip) begin
                    state_d = ST_FAULT;
                end else if (tick_q) begin
                    setpoint_d = stepped;
                    upd_d      = 1'b1;
                    if (stepped == target_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_d  = ST_IDLE;
                    target_d = setpoint_q;
                    oc_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            setpoint_q <= PARK_A;
            target_q   <= PARK_A;
            oc_q       <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            setpoint_q <= setpoint_d;
            target_q   <= target_d;
            oc_q       <= oc_d;
            upd_q      <= upd_d;
        end
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.setpoint     = setpoint_q;
    assign bus.setpoint_upd = upd_q;
    assign bus.frame_tick   = tick_q;
    assign bus.pwm_en       = (state_q != ST_FAULT);
    assign bus.busy         = (state_q == ST_RAMP);
    assign bus.fault        = (state_q == ST_FAULT);
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - directed and randomized checks against a per-frame angle/fault model
module tb_servo_motion_sequencer;
    localparam int FC = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    int m_set, m_tgt, m_oc, m_k;
    bit m_fault, m_upd;

    servo_motion_sequencer_if bus ();

    servo_motion_sequencer #(.FRAME_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_set = 90; m_tgt = 90; m_oc = 0; m_k = 0; m_fault = 0; m_upd = 0;
    endtask

    // One clock edge of the angle/fault rules, using inputs as seen at that edge.
    task automatic model_edge();
        bit tick    = (m_k == FC - 1);
        bit ramping = (m_set != m_tgt);
        bit hs      = bus.cmd_valid && !m_fault && !ramping;
        int clampd  = (int'(bus.cmd_angle) > 180) ? 180 : int'(bus.cmd_angle);
        m_upd = 0;
        if (m_fault) begin
            if (bus.fault_clr) begin
                m_fault = 0; m_tgt = m_set; m_oc = 0;
            end
        end else begin
            if (tick) m_oc = (int'(bus.current_meas) >= 3000) ? ((m_oc + 1 > 3) ? 3 : m_oc + 1) : 0;
            if (tick && m_oc >= 3) begin
                m_fault = 1;
                if (hs) m_tgt = clampd;
            end else if (tick && ramping) begin
                int d   = m_tgt - m_set;
                int mag = (d < 0) ? -d : d;
                int s   = (mag < 6) ? mag : 6;
                m_set = m_set + ((d < 0) ? -s : s);
                m_upd = 1;
            end else if (hs) begin
                m_tgt = clampd;
            end
        end
        m_k = (m_k + 1) % FC;
    endtask

    task automatic check_all();
        chk("setpoint", 32'(bus.setpoint), m_set);
        chk("setpoint_upd", 32'(bus.setpoint_upd), 32'(m_upd));
        chk("frame_tick", 32'(bus.frame_tick), 32'(m_k == FC - 1));
        chk("pwm_en", 32'(bus.pwm_en), 32'(!m_fault));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_fault && m_set == m_tgt));
        chk("busy", 32'(bus.busy), 32'(!m_fault && m_set != m_tgt));
        chk("fault", 32'(bus.fault), 32'(m_fault));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input int angle);
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = 8'(angle);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_frame(input int cur);
        bus.current_meas = 12'(cur);
        run_cycles(FC);
    endtask

    initial begin
        int frozen;
        bus.cmd_valid = 1'b0; bus.cmd_angle = '0; bus.current_meas = '0; bus.fault_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // 1: idle frames hold park angle
        run_cycles(3 * FC);
        chk("t1_setpoint", 32'(bus.setpoint), 90);

        // 2: ramp 90 -> 120
        send(120);
        run_cycles(6 * FC);
        chk("t2_setpoint", 32'(bus.setpoint), 120);
        chk("t2_busy", 32'(bus.busy), 0);

        // 3: clamp above max, then a sub-step move
        send(200);
        run_cycles(11 * FC);
        chk("t3_clamp", 32'(bus.setpoint), 180);
        send(90);
        run_cycles(16 * FC);
        send(88);
        run_cycles(2 * FC);
        chk("t3_small", 32'(bus.setpoint), 88);

        // 4: overcurrent trip mid-ramp, then clear
        bus.current_meas = 12'd3100;
        send(150);
        run_cycles(4 * FC);
        chk("t4_fault", 32'(bus.fault), 1);
        chk("t4_pwm", 32'(bus.pwm_en), 0);
        chk("t4_frozen", 32'(bus.setpoint), 100);
        frozen = int'(bus.setpoint);
        run_frame(3100);
        chk("t4_still", 32'(bus.setpoint), 32'(frozen));
        bus.current_meas = '0;
        bus.fault_clr = 1'b1;
        cyc();
        bus.fault_clr = 1'b0;
        chk("t4_clr", 32'(bus.fault), 0);
        chk("t4_ready", 32'(bus.cmd_ready), 1);
        run_frame(0);
        chk("t4_hold", 32'(bus.setpoint), 100);

        // 5: broken over-limit run does not trip (3000 is over, 2999 is under)
        send(40);
        run_frame(3000); run_frame(3000); run_frame(2999); run_frame(3000); run_frame(3000);
        chk("t5_nofault", 32'(bus.fault), 0);
        for (int f = 0; f < 6; f++) run_frame(0);
        chk("t5_setpoint", 32'(bus.setpoint), 40);

        // 6: async reset mid-ramp with a held-off command pending
        send(0);
        bus.cmd_valid = 1'b1;
        bus.cmd_angle = 8'd30;
        run_cycles(3 * FC + 50);
        chk("t6_heldoff", 32'(bus.cmd_ready), 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("t6_async_sp", 32'(bus.setpoint), 90);
        check_all();
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        run_cycles(2 * FC);
        chk("t6_setpoint", 32'(bus.setpoint), 90);
        chk("t6_busy", 32'(bus.busy), 0);

        // randomized commands, currents and clears
        for (int i = 0; i < 4000; i++) begin
            bus.cmd_valid    = ($urandom_range(0, 7) == 0);
            bus.cmd_angle    = 8'($urandom_range(0, 255));
            bus.fault_clr    = ($urandom_range(0, 39) == 0);
            bus.current_meas = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(3000, 4095))
                                                           : 12'($urandom_range(0, 2999));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
